// File: rtl/rv32ic_pkg.sv
// rv32ic_pkg: shared constants for the rv32ic_core slice.
//   - RV32I opcode, funct3 and funct7 encodings
//   - ALU operation enum and a funct3-to-ALU mapping helper
//   - RV32C quadrant and funct3 encodings used by rv32c_expander
package rv32ic_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // Compressed quadrants (instr[1:0]); 2'b11 means a 32-bit instruction
  localparam logic [1:0] C_Q0 = 2'b00;
  localparam logic [1:0] C_Q1 = 2'b01;
  localparam logic [1:0] C_Q2 = 2'b10;

  // Compressed funct3 (instr[15:13]) per quadrant
  localparam logic [2:0] C0_ADDI4SPN = 3'b000;
  localparam logic [2:0] C1_ADDI     = 3'b000;
  localparam logic [2:0] C1_JAL      = 3'b001;
  localparam logic [2:0] C1_LI       = 3'b010;
  localparam logic [2:0] C1_LUI      = 3'b011;
  localparam logic [2:0] C1_MISC_ALU = 3'b100;
  localparam logic [2:0] C1_J        = 3'b101;
  localparam logic [2:0] C1_BEQZ     = 3'b110;
  localparam logic [2:0] C1_BNEZ     = 3'b111;
  localparam logic [2:0] C2_SLLI     = 3'b000;
  localparam logic [2:0] C2_MISC     = 3'b100;

  // Map an ALU funct3 to an operation; alt selects SUB / SRA.
  function automatic alu_op_e alu_op_from(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  alu_op_from = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op_from = ALU_SLL;
      F3_SLT:  alu_op_from = ALU_SLT;
      F3_SLTU: alu_op_from = ALU_SLTU;
      F3_XOR:  alu_op_from = ALU_XOR;
      F3_SR:   alu_op_from = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op_from = ALU_OR;
      F3_AND:  alu_op_from = ALU_AND;
      default: alu_op_from = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rv32c_expander.sv
// rv32c_expander: combinational RV32C -> RV32I expander.
//   c_instr  in  16  compressed instruction (quadrant in [1:0])
//   instr    out 32  equivalent 32-bit instruction
//   illegal  out 1   encoding reserved or not supported by this core
// Only instantiated when RV32IC_COMPRESSED_EN is defined.
module rv32c_expander
  import rv32ic_pkg::*;
(
  input  logic [15:0] c_instr,
  output logic [31:0] instr,
  output logic        illegal
);

  logic [2:0]  f3_s;
  logic [4:0]  rd_s, rs2_s, rs1p_s, rs2p_s;
  logic [11:0] imm6_s, addi4spn_s, addi16sp_s;
  logic [19:0] lui_s;
  logic [20:0] cj_off_s;
  logic [12:0] cb_off_s;

  assign f3_s   = c_instr[15:13];
  assign rd_s   = c_instr[11:7];
  assign rs2_s  = c_instr[6:2];
  // Primed registers x8..x15
  assign rs1p_s = {2'b01, c_instr[9:7]};
  assign rs2p_s = {2'b01, c_instr[4:2]};

  // Scattered immediate fields reassembled into natural bit order
  assign imm6_s     = {{6{c_instr[12]}}, c_instr[12], c_instr[6:2]};
  assign addi4spn_s = {2'b00, c_instr[10:7], c_instr[12:11], c_instr[5], c_instr[6], 2'b00};
  assign addi16sp_s = {{3{c_instr[12]}}, c_instr[4:3], c_instr[5], c_instr[2], c_instr[6], 4'b0000};
  assign lui_s      = {{14{c_instr[12]}}, c_instr[12], c_instr[6:2]};
  assign cj_off_s   = {{9{c_instr[12]}}, c_instr[12], c_instr[8], c_instr[10:9], c_instr[6],
                       c_instr[7], c_instr[2], c_instr[11], c_instr[5:3], 1'b0};
  assign cb_off_s   = {{4{c_instr[12]}}, c_instr[12], c_instr[6:5], c_instr[2],
                       c_instr[11:10], c_instr[4:3], 1'b0};

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    enc_i = {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    enc_r = {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    enc_b = {off[12], off[10:5], 5'd0, rs1, f3, off[4:1], off[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
    enc_j = {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
  endfunction

  // Quadrant / funct3 decode into the equivalent 32-bit encoding
  always_comb begin
    instr   = 32'h0000_0000;
    illegal = 1'b1;
    case (c_instr[1:0])
      C_Q0: begin
        case (f3_s)
          C0_ADDI4SPN: begin
            instr   = enc_i(addi4spn_s, 5'd2, F3_ADD, rs2p_s, OPC_OP_IMM);
            illegal = (addi4spn_s == 12'd0);
          end
          default: illegal = 1'b1;
        endcase
      end
      C_Q1: begin
        case (f3_s)
          C1_ADDI: begin
            instr   = enc_i(imm6_s, rd_s, F3_ADD, rd_s, OPC_OP_IMM);
            illegal = 1'b0;
          end
          C1_JAL: begin
            instr   = enc_j(cj_off_s, 5'd1);
            illegal = 1'b0;
          end
          C1_LI: begin
            instr   = enc_i(imm6_s, 5'd0, F3_ADD, rd_s, OPC_OP_IMM);
            illegal = 1'b0;
          end
          C1_LUI: begin
            if (rd_s == 5'd2) begin
              instr   = enc_i(addi16sp_s, 5'd2, F3_ADD, 5'd2, OPC_OP_IMM);
              illegal = (addi16sp_s == 12'd0);
            end else begin
              instr   = {lui_s, rd_s, OPC_LUI};
              illegal = (imm6_s == 12'd0);
            end
          end
          C1_MISC_ALU: begin
            case (c_instr[11:10])
              2'b00: begin
                instr   = enc_i({F7_BASE, rs2_s}, rs1p_s, F3_SR, rs1p_s, OPC_OP_IMM);
                illegal = c_instr[12];
              end
              2'b01: begin
                instr   = enc_i({F7_ALT, rs2_s}, rs1p_s, F3_SR, rs1p_s, OPC_OP_IMM);
                illegal = c_instr[12];
              end
              2'b10: begin
                instr   = enc_i(imm6_s, rs1p_s, F3_AND, rs1p_s, OPC_OP_IMM);
                illegal = 1'b0;
              end
              default: begin
                // c_instr[12]=1 selects RV64-only word ops
                illegal = c_instr[12];
                case (c_instr[6:5])
                  2'b00:   instr = enc_r(F7_ALT,  rs2p_s, rs1p_s, F3_ADD, rs1p_s);
                  2'b01:   instr = enc_r(F7_BASE, rs2p_s, rs1p_s, F3_XOR, rs1p_s);
                  2'b10:   instr = enc_r(F7_BASE, rs2p_s, rs1p_s, F3_OR,  rs1p_s);
                  default: instr = enc_r(F7_BASE, rs2p_s, rs1p_s, F3_AND, rs1p_s);
                endcase
              end
            endcase
          end
          C1_J: begin
            instr   = enc_j(cj_off_s, 5'd0);
            illegal = 1'b0;
          end
          C1_BEQZ: begin
            instr   = enc_b(cb_off_s, rs1p_s, F3_BEQ);
            illegal = 1'b0;
          end
          default: begin
            instr   = enc_b(cb_off_s, rs1p_s, F3_BNE);
            illegal = 1'b0;
          end
        endcase
      end
      C_Q2: begin
        case (f3_s)
          C2_SLLI: begin
            instr   = enc_i({F7_BASE, rs2_s}, rd_s, F3_SLL, rd_s, OPC_OP_IMM);
            illegal = c_instr[12];
          end
          C2_MISC: begin
            if (!c_instr[12]) begin
              if (rs2_s == 5'd0) begin
                instr   = enc_i(12'd0, rd_s, F3_ADD, 5'd0, OPC_JALR);
                illegal = (rd_s == 5'd0);
              end else begin
                instr   = enc_r(F7_BASE, rs2_s, 5'd0, F3_ADD, rd_s);
                illegal = 1'b0;
              end
            end else begin
              if (rs2_s == 5'd0) begin
                // rd=0 here is EBREAK, which this core does not execute
                instr   = enc_i(12'd0, rd_s, F3_ADD, 5'd1, OPC_JALR);
                illegal = (rd_s == 5'd0);
              end else begin
                instr   = enc_r(F7_BASE, rs2_s, rd_s, F3_ADD, rd_s);
                illegal = 1'b0;
              end
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32ic_core.sv
// rv32ic_core: single-cycle RV32I integer core, one instruction retired per clock.
//   clk, rst_n    clock / asynchronous active-low reset
//   imem_addr     out 32  fetch address (== pc)
//   imem_rdata    in  32  combinational instruction word at imem_addr
//   pc            out 32  current program counter
//   illegal_instr out 1   current instruction unsupported (combinational)
//   dbg_reg_addr  in  5   debug register index
//   dbg_reg_data  out 32  x[dbg_reg_addr], 0 for x0
// Optional: define RV32IC_COMPRESSED_EN to execute 16-bit RV32C instructions.
// Without it every 16-bit encoding is illegal and jump targets are word aligned.
module rv32ic_core
  import rv32ic_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [31:0]     imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     pc,
  output logic            illegal_instr,
  input  logic [4:0]      dbg_reg_addr,
  output logic [XLEN-1:0] dbg_reg_data
);

  logic [31:0]     pc_r;
  logic [XLEN-1:0] regs_r [0:31];

  logic            is_32_s, c_illegal_s;
  logic [31:0]     instr_s;
  logic [6:0]      opcode_s, f7_s;
  logic [4:0]      rd_s, rs1_s, rs2_s;
  logic [2:0]      f3_s;
  logic [31:0]     imm_i_s, imm_b_s, imm_u_s, imm_j_s;
  logic [XLEN-1:0] rs1_val_s, rs2_val_s;

  alu_op_e         alu_op_s;
  logic [XLEN-1:0] alu_a_s, alu_b_s, alu_res_s, wr_data_s;
  logic            legal_s, wr_en_s, link_s, take_s, illegal_s, wr_s;
  logic [31:0]     target_raw_s, target_s, seq_pc_s, next_pc_s;

  assign is_32_s = (imem_rdata[1:0] == 2'b11);

`ifdef RV32IC_COMPRESSED_EN
  logic [31:0] exp_instr_s;
  logic        exp_illegal_s;

  rv32c_expander u_expander (
    .c_instr (imem_rdata[15:0]),
    .instr   (exp_instr_s),
    .illegal (exp_illegal_s)
  );

  assign instr_s     = is_32_s ? imem_rdata : exp_instr_s;
  assign c_illegal_s = !is_32_s && exp_illegal_s;
  assign target_s    = {target_raw_s[31:1], 1'b0};
`else
  assign instr_s     = imem_rdata;
  assign c_illegal_s = !is_32_s;
  assign target_s    = {target_raw_s[31:2], 2'b00};
`endif

  assign opcode_s = instr_s[6:0];
  assign rd_s     = instr_s[11:7];
  assign f3_s     = instr_s[14:12];
  assign rs1_s    = instr_s[19:15];
  assign rs2_s    = instr_s[24:20];
  assign f7_s     = instr_s[31:25];

  assign imm_i_s = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_b_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s = {instr_s[31:12], 12'h000};
  assign imm_j_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

  assign rs1_val_s    = (rs1_s == 5'd0) ? {XLEN{1'b0}} : regs_r[rs1_s];
  assign rs2_val_s    = (rs2_s == 5'd0) ? {XLEN{1'b0}} : regs_r[rs2_s];
  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? {XLEN{1'b0}} : regs_r[dbg_reg_addr];

  assign seq_pc_s = pc_r + (is_32_s ? 32'd4 : 32'd2);

  // Instruction decode: operand selection, legality and control-flow target
  always_comb begin
    alu_op_s     = ALU_ADD;
    alu_a_s      = rs1_val_s;
    alu_b_s      = imm_i_s;
    wr_en_s      = 1'b0;
    link_s       = 1'b0;
    legal_s      = 1'b0;
    take_s       = 1'b0;
    target_raw_s = pc_r + imm_b_s;
    case (opcode_s)
      OPC_LUI: begin
        alu_a_s = {XLEN{1'b0}};
        alu_b_s = imm_u_s;
        wr_en_s = 1'b1;
        legal_s = 1'b1;
      end
      OPC_AUIPC: begin
        alu_a_s = pc_r;
        alu_b_s = imm_u_s;
        wr_en_s = 1'b1;
        legal_s = 1'b1;
      end
      OPC_JAL: begin
        target_raw_s = pc_r + imm_j_s;
        take_s       = 1'b1;
        link_s       = 1'b1;
        wr_en_s      = 1'b1;
        legal_s      = 1'b1;
      end
      OPC_JALR: begin
        target_raw_s = rs1_val_s + imm_i_s;
        take_s       = 1'b1;
        link_s       = 1'b1;
        wr_en_s      = 1'b1;
        legal_s      = (f3_s == 3'b000);
      end
      OPC_BRANCH: begin
        legal_s = 1'b1;
        case (f3_s)
          F3_BEQ:  take_s = (rs1_val_s == rs2_val_s);
          F3_BNE:  take_s = (rs1_val_s != rs2_val_s);
          F3_BLT:  take_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
          F3_BGE:  take_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
          F3_BLTU: take_s = (rs1_val_s < rs2_val_s);
          F3_BGEU: take_s = (rs1_val_s >= rs2_val_s);
          default: begin
            take_s  = 1'b0;
            legal_s = 1'b0;
          end
        endcase
      end
      OPC_OP_IMM: begin
        // Only shifts carry funct7; for ADDI etc. those bits are immediate
        alu_op_s = alu_op_from(f3_s, (f3_s == F3_SR) && f7_s[5]);
        wr_en_s  = 1'b1;
        case (f3_s)
          F3_SLL:  legal_s = (f7_s == F7_BASE);
          F3_SR:   legal_s = (f7_s == F7_BASE) || (f7_s == F7_ALT);
          default: legal_s = 1'b1;
        endcase
      end
      OPC_OP: begin
        alu_op_s = alu_op_from(f3_s, f7_s[5]);
        alu_b_s  = rs2_val_s;
        wr_en_s  = 1'b1;
        legal_s  = (f7_s == F7_BASE) ||
                   ((f7_s == F7_ALT) && ((f3_s == F3_ADD) || (f3_s == F3_SR)));
      end
      default: legal_s = 1'b0;
    endcase
  end

  // ALU
  always_comb begin
    case (alu_op_s)
      ALU_ADD:  alu_res_s = alu_a_s + alu_b_s;
      ALU_SUB:  alu_res_s = alu_a_s - alu_b_s;
      ALU_SLL:  alu_res_s = alu_a_s << alu_b_s[4:0];
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(alu_a_s) < $signed(alu_b_s))};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (alu_a_s < alu_b_s)};
      ALU_XOR:  alu_res_s = alu_a_s ^ alu_b_s;
      ALU_SRL:  alu_res_s = alu_a_s >> alu_b_s[4:0];
      ALU_SRA:  alu_res_s = $unsigned($signed(alu_a_s) >>> alu_b_s[4:0]);
      ALU_OR:   alu_res_s = alu_a_s | alu_b_s;
      ALU_AND:  alu_res_s = alu_a_s & alu_b_s;
      default:  alu_res_s = alu_a_s + alu_b_s;
    endcase
  end

  assign illegal_s = c_illegal_s || !legal_s;
  assign wr_s      = wr_en_s && !illegal_s && (rd_s != 5'd0);
  assign wr_data_s = link_s ? seq_pc_s : alu_res_s;

  // Next pc: illegal instructions fall through by their own length
  always_comb begin
    if (take_s && !illegal_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = seq_pc_s;
    end
  end

  // Architectural state: pc and register file retire on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      pc_r <= next_pc_s;
      if (wr_s) begin
        regs_r[rd_s] <= wr_data_s;
      end
    end
  end

  assign pc            = pc_r;
  assign imem_addr     = pc_r;
  assign illegal_instr = illegal_s;

endmodule

// File: tb/tb_rv32ic_core.sv
module tb_rv32ic_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] imem_addr, imem_rdata, pc, dbg_reg_data;
  logic        illegal_instr;
  logic [4:0]  dbg_reg_addr = 5'd0;

  logic [15:0] mem [0:255];
  logic [7:0]  hidx;

  typedef struct { logic ill; logic [31:0] pc; } step_t;
  typedef struct { logic [4:0] idx; logic [31:0] val; } reg_t;
  step_t step_q[$];
  reg_t  reg_q[$];

  int checks = 0;
  int errors = 0;

`ifdef RV32IC_COMPRESSED_EN
  localparam bit C_EN = 1'b1;
`else
  localparam bit C_EN = 1'b0;
`endif

  rv32ic_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .illegal_instr (illegal_instr),
    .dbg_reg_addr  (dbg_reg_addr),
    .dbg_reg_data  (dbg_reg_data)
  );

  always #5 clk = ~clk;

  assign hidx       = imem_addr[8:1];
  assign imem_rdata = {mem[hidx + 8'd1], mem[hidx]};

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [15:0] c_li(input logic [4:0] rd, input logic [5:0] imm);
    return {3'b010, imm[5], rd, imm[4:0], 2'b01};
  endfunction
  function automatic logic [15:0] c_alu(input logic [1:0] f2, input logic [2:0] rdp,
                                        input logic [2:0] rsp);
    return {3'b100, 1'b0, 2'b11, rdp, f2, rsp, 2'b01};
  endfunction
  function automatic logic [15:0] c_br(input logic [2:0] f3, input logic [2:0] rsp,
                                       input logic [8:0] off);
    return {f3, off[8], off[4:3], rsp, off[7:6], off[2:1], off[5], 2'b01};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask
  task automatic put32(input int addr, input logic [31:0] w);
    mem[addr/2]     = w[15:0];
    mem[addr/2 + 1] = w[31:16];
  endtask
  task automatic put16(input int addr, input logic [15:0] h);
    mem[addr/2] = h;
  endtask
  task automatic push_step(input logic ill, input logic [31:0] npc);
    step_t s;
    s.ill = ill;
    s.pc  = npc;
    step_q.push_back(s);
  endtask
  task automatic push_reg(input logic [4:0] idx, input logic [31:0] val);
    reg_t r;
    r.idx = idx;
    r.val = val;
    reg_q.push_back(r);
  endtask
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_mem();
    put32(0,  enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
    put32(4,  enc_i(12'd3, 5'd0, 3'b000, 5'd2, 7'b0010011));
    put32(8,  enc_r(7'd0, 5'd2, 5'd1, 3'b111, 5'd3));
    put32(12, enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd4));
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    for (int i = 1; i < 32; i += 10) begin
      dbg_reg_addr = 5'(i);
      #1;
      checks++;
      if (dbg_reg_data !== 32'h0) begin errors++; $display("FAIL reset_x%0d: got %h expected 0", i, dbg_reg_data); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick();
    dbg_reg_addr = 5'd3;
    #1;
    checks++;
    if (dbg_reg_data !== 32'd1) begin errors++; $display("FAIL premid_x3: got %h expected 1", dbg_reg_data); end
    // assert reset mid-cycle, away from any clock edge
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL midreset_pc: got %h expected 00000000", pc); end
    for (int i = 1; i <= 3; i++) begin
      dbg_reg_addr = 5'(i);
      #0.5;
      checks++;
      if (dbg_reg_data !== 32'h0) begin errors++; $display("FAIL midreset_x%0d: got %h expected 0", i, dbg_reg_data); end
    end
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h0) begin errors++; $display("FAIL reset_hold_pc: got %h expected 00000000", pc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_queues(input string tag);
    step_t s;
    reg_t  r;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      checks++;
      if (illegal_instr !== s.ill) begin
        errors++; $display("FAIL %s illegal at pc %h: got %b expected %b", tag, pc, illegal_instr, s.ill);
      end
      tick();
      checks++;
      if (pc !== s.pc) begin
        errors++; $display("FAIL %s pc: got %h expected %h", tag, pc, s.pc);
      end
    end
    while (reg_q.size() > 0) begin
      r = reg_q.pop_front();
      dbg_reg_addr = r.idx;
      #0.5;
      checks++;
      if (dbg_reg_data !== r.val) begin
        errors++; $display("FAIL %s x%0d: got %h expected %h", tag, r.idx, dbg_reg_data, r.val);
      end
    end
  endtask

  task automatic test_alu_basic();
    clear_mem();
    put32(0,  enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
    put32(4,  enc_i(12'd3, 5'd0, 3'b000, 5'd2, 7'b0010011));
    put32(8,  enc_r(7'd0, 5'd2, 5'd1, 3'b111, 5'd3));
    put32(12, enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd4));
    apply_reset();
    for (int i = 1; i <= 4; i++) push_step(1'b0, 32'(4 * i));
    push_reg(5'd3, 32'd1);
    push_reg(5'd4, 32'd8);
    run_queues("alu_basic");
  endtask

  task automatic test_compressed_alu();
    clear_mem();
    put16(0, c_li(5'd8, 6'd12));
    put16(2, c_li(5'd9, 6'd10));
    put16(4, c_alu(2'b11, 3'd0, 3'd1));
    put16(6, c_alu(2'b00, 3'd1, 3'd0));
    apply_reset();
    for (int i = 1; i <= 4; i++) push_step(!C_EN, 32'(2 * i));
    push_reg(5'd8, C_EN ? 32'd8 : 32'd0);
    push_reg(5'd9, C_EN ? 32'd2 : 32'd0);
    run_queues("c_alu");
  endtask

  task automatic test_compressed_branch();
    clear_mem();
    put16(0, c_li(5'd8, 6'd0));
    put16(2, c_br(3'b110, 3'd0, 9'd6));
    put16(8, c_br(3'b111, 3'd0, 9'd4));
    apply_reset();
    push_step(!C_EN, 32'd2);
    push_step(!C_EN, C_EN ? 32'd8 : 32'd4);
    push_step(!C_EN, C_EN ? 32'd10 : 32'd6);
    push_reg(5'd8, 32'd0);
    run_queues("c_branch");
  endtask

  task automatic test_compare_shift();
    clear_mem();
    put32(0,  enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011));
    put32(4,  enc_i(12'd0,   5'd1, 3'b010, 5'd2, 7'b0010011));
    put32(8,  enc_i(12'd1,   5'd1, 3'b011, 5'd3, 7'b0010011));
    put32(12, enc_i(12'd4,   5'd1, 3'b001, 5'd4, 7'b0010011));
    apply_reset();
    for (int i = 1; i <= 4; i++) push_step(1'b0, 32'(4 * i));
    push_reg(5'd1, 32'hFFFF_FFFF);
    push_reg(5'd2, 32'd1);
    push_reg(5'd3, 32'd0);
    push_reg(5'd4, 32'hFFFF_FFF0);
    run_queues("cmp_shift");
  endtask

  task automatic test_x0_illegal();
    clear_mem();
    put32(0,  enc_i(12'd9, 5'd0, 3'b000, 5'd1, 7'b0010011));
    put32(4,  enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011));
    put16(8,  16'h0000);
    put32(10, enc_i(12'd1, 5'd1, 3'b000, 5'd2, 7'b0010011));
    apply_reset();
    push_step(1'b0, 32'd4);
    push_step(1'b0, 32'd8);
    push_step(1'b1, 32'd10);
    push_step(1'b0, 32'd14);
    push_reg(5'd0, 32'd0);
    push_reg(5'd1, 32'd9);
    push_reg(5'd2, 32'd10);
    run_queues("x0_illegal");
  endtask

  task automatic test_branch_jump();
    clear_mem();
    put32(0,  enc_i(12'hFF0, 5'd0, 3'b000, 5'd1, 7'b0010011));       // ADDI x1,x0,-16
    put32(4,  enc_i({7'b0100000, 5'd2}, 5'd1, 3'b101, 5'd2, 7'b0010011)); // SRAI x2,x1,2
    put32(8,  enc_i({7'b0000000, 5'd28}, 5'd1, 3'b101, 5'd3, 7'b0010011)); // SRLI x3,x1,28
    put32(12, enc_b(13'd8, 5'd0, 5'd1, 3'b100));                       // BLT x1,x0,+8
    put32(20, enc_j(21'd12, 5'd5));                                    // JAL x5,+12
    put32(32, enc_i(12'd33, 5'd3, 3'b000, 5'd6, 7'b1100111));          // JALR x6,x3,33
    put32(48, enc_r(7'b0100000, 5'd3, 5'd0, 3'b000, 5'd7));            // SUB x7,x0,x3
    put32(52, enc_b(13'd8, 5'd1, 5'd3, 3'b111));                       // BGEU x3,x1,+8
    put32(56, enc_r(7'd0, 5'd1, 5'd3, 3'b011, 5'd8));                  // SLTU x8,x3,x1
    apply_reset();
    push_step(1'b0, 32'd4);
    push_step(1'b0, 32'd8);
    push_step(1'b0, 32'd12);
    push_step(1'b0, 32'd20);
    push_step(1'b0, 32'd32);
    push_step(1'b0, 32'd48);
    push_step(1'b0, 32'd52);
    push_step(1'b0, 32'd56);
    push_step(1'b0, 32'd60);
    push_reg(5'd2, 32'hFFFF_FFFC);
    push_reg(5'd3, 32'h0000_000F);
    push_reg(5'd5, 32'd24);
    push_reg(5'd6, 32'd36);
    push_reg(5'd7, 32'hFFFF_FFF1);
    push_reg(5'd8, 32'd1);
    run_queues("branch_jump");
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_compressed_alu();
    test_compressed_branch();
    test_compare_shift();
    test_x0_illegal();
    test_branch_jump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32ic_core.md
Name: rv32ic_core

Overview:
- Single-cycle RV32I integer-subset core with optional RV32C compressed-instruction support.
- Fetches one instruction per clock from an external combinational instruction memory, executes it and retires it in the same cycle.
- Exposes a debug register-read port for directed arithmetic/logic/branch tests.
- Sits beside the instruction memory inside the core+memory top.
- No data memory: loads, stores, FENCE and SYSTEM are out of scope.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- XLEN, 32, datapath width; fixed at 32, not to be overridden.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address of the current instruction; equals pc.
- imem_rdata  in  32  bytes imem_addr..imem_addr+3, little-endian, combinational (same cycle).
- pc  out  32  current program counter.
- illegal_instr  out  1  high while the current instruction is unsupported.
- dbg_reg_addr  in  5  register index for debug read.
- dbg_reg_data  out  32  combinational value of x[dbg_reg_addr]; 0 when the index is 0.

Behaviour:
- Reset (asynchronous on rst_n low):
  - pc = RESET_PC.
  - x1..x31 = 0.
  - illegal_instr follows decode of imem_rdata; it is not registered.
- While rst_n is low, the registers hold their reset values regardless of clk.
- First fetch occurs in the cycle after rst_n rises.
- x0 is hardwired to zero; writes to x0 are discarded.
- Latency: exactly one instruction per clock. The register write and pc update occur on the same rising edge.
- Supported 32-bit instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Arithmetic rules:
  - All arithmetic is modulo 2^32.
  - Immediates are sign-extended from bit 31.
  - SLTIU compares against the sign-extended immediate treated as unsigned.
  - Shift amount is the low 5 bits of the operand.
  - SRA and SRAI replicate bit 31.
- Next pc:
  - Sequential: pc + 4 for 32-bit instructions, pc + 2 for 16-bit.
  - Branches and JAL: target = pc + sign-extended offset of the current instruction.
  - JALR: target = (rs1 + imm) & ~1.
  - Link value = pc + 4 for 32-bit or pc + 2 for 16-bit.
- Instruction length: imem_rdata[1:0] == 2'b11 selects 32-bit; otherwise 16-bit.
- pc may be halfword-aligned. The memory supplies the unaligned word, so the core needs no internal buffering.
- Illegal or unsupported encodings (including all-zero 16'h0000):
  - illegal_instr = 1.
  - No register write.
  - pc advances by the instruction length.
- Target alignment: a misaligned target (bit 0 set after masking) cannot occur. Branch/JAL targets with bit 1 set are legal only when compressed support is compiled in; otherwise the core forces bit 1 to 0.
- Reset mid-operation: immediate asynchronous return to the reset state. The in-flight instruction is not retired.

Optional Feature:
- Macro RV32IC_COMPRESSED_EN.
- Defined: 16-bit instructions are expanded to their 32-bit equivalents before decode. Supported forms:
  - C.ADDI, C.LI, C.LUI, C.ADDI16SP, C.ADDI4SPN.
  - C.SLLI, C.SRLI, C.SRAI, C.ANDI.
  - C.MV, C.ADD, C.SUB, C.XOR, C.OR, C.AND.
  - C.J, C.JAL, C.JR, C.JALR.
  - C.BEQZ, C.BNEZ, C.NOP.
  - Reserved encodings (e.g. C.ADDI4SPN with nzuimm = 0) are illegal.
- Undefined: any instruction with [1:0] != 2'b11 is illegal and pc advances by 2; branch/jump targets have bit 1 forced to 0.

Decomposition:
- Package rv32ic_pkg holds:
  - opcode constants (OP, OP_IMM, BRANCH, JAL, JALR, LUI, AUIPC);
  - funct3/funct7 constants;
  - ALU operation enum;
  - compressed quadrant/funct3 constants.
- One natural sub-module: rv32c_expander (combinational 16-to-32-bit expander plus illegal flag). It is instantiated only under RV32IC_COMPRESSED_EN.
- The ALU and register file stay inline.

Test Plan:
- Reset, then ADDI x1,x0,5; ADDI x2,x0,3; AND x3,x1,x2; ADD x4,x1,x2 -> x3 = 1, x4 = 8; pc = 16 after 4 cycles.
- C.LI x8,12; C.LI x9,10; C.AND x8,x9; C.SUB x9,x8 -> x8 = 8, x9 = 2; pc advances by 2 per cycle (8 after 4 cycles).
- C.LI x8,0; C.BEQZ x8,+6 at pc = 2 -> pc = 8. Then C.BNEZ x8,+4 -> not taken, pc += 2.
- ADDI x1,x0,-1; SLTI x2,x1,0; SLTIU x3,x1,1; SLLI x4,x1,4 -> x2 = 1, x3 = 0, x4 = 32'hFFFF_FFF0.
- ADDI x0,x0,7, then an all-zero 16-bit word -> x0 remains 0; illegal_instr = 1 for one cycle; pc += 2; no register change.
- Assert rst_n low mid-program -> pc = RESET_PC and all registers = 0 immediately, without waiting for a clock edge.
